// File: rtl/vec_addsub_sat_pipe_pkg.sv
// Shared constants and helpers for the vector add/subtract saturating pipeline.
// Latency: n/a (package only).
// Backpressure: n/a.
package vec_addsub_sat_pipe_pkg;

    // Operation select carried with each beat.
    localparam logic MODE_ADD  = 1'b0;
    localparam logic MODE_SUB  = 1'b1;

    // Overflow handling select carried with each beat.
    localparam logic SAT_WRAP  = 1'b0;
    localparam logic SAT_CLAMP = 1'b1;

    // Largest representable value of a w-bit two's-complement lane.
    function automatic int lane_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest representable value of a w-bit two's-complement lane.
    function automatic int lane_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/vec_addsub_sat_pipe_lane.sv
// Single-lane signed add/subtract with optional clamp to the lane range.
// Latency: 0 (purely combinational).
// Backpressure: n/a.
// Ports: a, b operands; sub selects a-b; sat selects clamp vs wrap;
//        d result; ovf set whenever the exact result leaves the W-bit range.
module lane_addsub_sat
    import vec_addsub_sat_pipe_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         sat,
    output logic [W-1:0] d,
    output logic         ovf
);

    localparam logic [W-1:0] LMAX = W'(lane_max(W));
    localparam logic [W-1:0] LMIN = W'(lane_min(W));

    logic [W:0] a_x;
    logic [W:0] b_x;
    logic [W:0] exact;

    // One extra bit holds every sum/difference of two W-bit values exactly,
    // including 0 - MIN, so no special case is needed.
    assign a_x   = {a[W-1], a};
    assign b_x   = {b[W-1], b};
    assign exact = (sub == MODE_SUB) ? (a_x - b_x) : (a_x + b_x);

    // Out of range exactly when the top two bits disagree; exact[W] then
    // gives the true sign and so the direction of the overflow.
    assign ovf = exact[W] ^ exact[W-1];

    always_comb begin
        d = exact[W-1:0];
        if ((sat == SAT_CLAMP) && ovf) begin
            d = exact[W] ? LMIN : LMAX;
        end
    end

endmodule

// File: rtl/vec_addsub_sat_pipe.sv
// Wc-lane vector add/subtract with per-beat clamp/wrap, overflow flags and a sticky overflow counter.
// Latency: 2 cycles accept-to-out_valid, one beat per cycle throughput.
// Backpressure: full valid/ready; in_ready = !s1_valid | !s2_valid | out_ready, no in_valid->in_ready path.
// Ports: clk, rst (async active-low); in_valid/in_ready/in_sub/in_sat/X/Y input beat;
//        out_valid/out_ready/D/ovf result beat; sat_cnt overflow-beat count, sat_clr clears it.
module vec_addsub_sat_pipe
    import vec_addsub_sat_pipe_pkg::*;
#(
    parameter int W     = 10,
    parameter int Wc    = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sub,
    input  logic              in_sat,
    input  logic [Wc*W-1:0]   X,
    input  logic [Wc*W-1:0]   Y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Wc*W-1:0]   D,
    output logic [Wc-1:0]     ovf,
    output logic [CNT_W-1:0]  sat_cnt,
    input  logic              sat_clr
);

    logic              s1_valid;
    logic [Wc*W-1:0]   s1_x;
    logic [Wc*W-1:0]   s1_y;
    logic              s1_sub;
    logic              s1_sat;

    logic              s2_valid;
    logic [Wc*W-1:0]   d_q;
    logic [Wc-1:0]     ovf_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              en1;
    logic              en2;
    logic              out_xfer;
    logic [Wc*W-1:0]   lane_d;
    logic [Wc-1:0]     lane_ovf;

    // Each stage advances when it is empty or the stage after it is moving,
    // so a full pipe accepts and emits in the same cycle without a bubble.
    assign en2      = !s2_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;
    assign out_xfer = s2_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_sub   <= MODE_ADD;
            s1_sat   <= SAT_WRAP;
        end else if (en1) begin
            s1_valid <= in_valid;
            s1_x     <= X;
            s1_y     <= Y;
            s1_sub   <= in_sub;
            s1_sat   <= in_sat;
        end
    end

    for (genvar i = 0; i < Wc; i++) begin : g_lane
        lane_addsub_sat #(
            .W (W)
        ) u_lane (
            .a   (s1_x[i*W +: W]),
            .b   (s1_y[i*W +: W]),
            .sub (s1_sub),
            .sat (s1_sat),
            .d   (lane_d[i*W +: W]),
            .ovf (lane_ovf[i])
        );
    end

    // Stage 2 only loads when empty or draining, which keeps D/ovf frozen
    // while a presented beat is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            d_q      <= '0;
            ovf_q    <= '0;
        end else if (en2) begin
            s2_valid <= s1_valid;
            d_q      <= lane_d;
            ovf_q    <= lane_ovf;
        end
    end

    // Counts delivered beats carrying any overflow; pins at all-ones and
    // lets a clear win over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (sat_clr) begin
            cnt_q <= '0;
        end else if (out_xfer && (|ovf_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = s2_valid;
    assign D         = d_q;
    assign ovf       = ovf_q;
    assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_vec_addsub_sat_pipe.sv
// Scoreboard bench for vec_addsub_sat_pipe (W=10, Wc=4, CNT_W=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_vec_addsub_sat_pipe;

    localparam int W  = 10;
    localparam int WC = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [WC*W-1:0] d;
        logic [WC-1:0]   o;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_sub;
    logic              in_sat;
    logic [WC*W-1:0]   X;
    logic [WC*W-1:0]   Y;
    logic              out_valid;
    logic              out_ready;
    logic [WC*W-1:0]   D;
    logic [WC-1:0]     ovf;
    logic [CW-1:0]     sat_cnt;
    logic              sat_clr;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    vec_addsub_sat_pipe #(
        .W     (W),
        .Wc    (WC),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_sat    (in_sat),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .ovf       (ovf),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WC*W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        logic [WC*W-1:0] r;
        r[9:0]   = a0[9:0];
        r[19:10] = a1[9:0];
        r[29:20] = a2[9:0];
        r[39:30] = a3[9:0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual D=%0h required no beat", D);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat_D", D, e.d);
                chk("beat_ovf", {60'd0, ovf}, {60'd0, e.o});
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic sub, input logic sat, input logic [WC*W-1:0] x,
                        input logic [WC*W-1:0] y, input logic [WC*W-1:0] ed, input logic [WC-1:0] eo);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_sub   = sub;
        in_sat   = sat;
        X        = x;
        Y        = y;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back('{d: ed, o: eo});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not accepted required=accepted");
        end
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 60) begin
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain actual=%0d pending required=0", name, sb.size());
        end
    endtask

    logic [WC*W-1:0] bx[4];
    logic [WC*W-1:0] by[4];
    logic [WC*W-1:0] bd[4];
    logic [WC-1:0]   bo[4];
    logic            bs[4];

    initial begin
        int  k;
        bit  acc;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        in_sat    = 1'b0;
        X         = '0;
        Y         = '0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;

        // Reset state.
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_D", D, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;

        // Basic subtract/saturate, then overflow cases; counter pins at 3.
        send(1, 1, pk(100, 0, -5, 511), pk(30, 1, 5, 0), pk(70, -1, -10, 511), 4'b0000);
        drain("sub_basic");
        chk("cnt_after_basic", sat_cnt, 0);

        send(1, 1, pk(500, 0, 0, 0), pk(-100, 0, 0, 0), pk(511, 0, 0, 0), 4'b0001);
        drain("sub_sat_ovf");
        chk("cnt_after_sub_sat", sat_cnt, 1);

        send(1, 0, pk(500, 0, 0, 0), pk(-100, 0, 0, 0), pk(-424, 0, 0, 0), 4'b0001);
        drain("sub_wrap_ovf");
        chk("cnt_after_sub_wrap", sat_cnt, 2);

        send(0, 1, pk(1, -1, -400, 511), pk(2, 1, -200, 0), pk(3, 0, -512, 511), 4'b0100);
        drain("add_sat_unf");
        chk("cnt_after_add_sat", sat_cnt, 3);

        send(1, 1, pk(0, 0, 0, 0), pk(0, 0, 0, -512), pk(0, 0, 0, 511), 4'b1000);
        drain("sub_min");
        chk("cnt_hold_4", sat_cnt, 3);

        send(0, 0, pk(0, 511, 0, 0), pk(0, 1, 0, 0), pk(0, -512, 0, 0), 4'b0010);
        drain("add_wrap_ovf");
        chk("cnt_hold_5", sat_cnt, 3);

        // Clear coinciding with an overflowing output transfer.
        out_ready = 1'b0;
        send(0, 1, pk(-512, 0, 0, 0), pk(-1, 0, 0, 0), pk(-512, 0, 0, 0), 4'b0001);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("clr_beat_presented", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        sat_clr   = 1'b1;
        @(posedge clk); #1;
        sat_clr   = 1'b0;
        chk("cnt_clr_priority", sat_cnt, 0);
        drain("clr_beat");

        // Backpressure: four beats against a stalled output.
        bs[0] = 0; bx[0] = pk(511, 0, 0, 0);      by[0] = pk(1, 0, 0, 0);       bd[0] = pk(511, 0, 0, 0);     bo[0] = 4'b0001;
        bs[1] = 0; bx[1] = pk(1, 2, 3, 4);        by[1] = pk(10, 20, 30, 40);   bd[1] = pk(11, 22, 33, 44);   bo[1] = 4'b0000;
        bs[2] = 1; bx[2] = pk(10, 10, 10, 10);    by[2] = pk(1, 2, 3, 4);       bd[2] = pk(9, 8, 7, 6);       bo[2] = 4'b0000;
        bs[3] = 0; bx[3] = pk(-1, -2, -3, -4);    by[3] = pk(-1, -2, -3, -4);   bd[3] = pk(-2, -4, -6, -8);   bo[3] = 4'b0000;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            if (c == 8) out_ready = 1'b1;
            in_valid = 1'b1;
            in_sub   = bs[k];
            in_sat   = 1'b1;
            X        = bx[k];
            Y        = by[k];
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back('{d: bd[k], o: bo[k]});
            if (c == 6 || c == 7) begin
                chk("bp_accepted_2", k, 2);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_D_stable", D, bd[0]);
                chk("bp_ovf_stable", ovf, bo[0]);
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", k, 4);
        drain("backpressure");
        chk("cnt_after_bp", sat_cnt, 1);

        // Asynchronous reset with two beats in flight.
        send(0, 1, pk(5, 5, 5, 5), pk(1, 1, 1, 1), pk(6, 6, 6, 6), 4'b0000);
        send(0, 1, pk(5, 5, 5, 5), pk(2, 2, 2, 2), pk(7, 7, 7, 7), 4'b0000);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_sat_cnt", sat_cnt, 0);
        chk("arst_D", D, 0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_pipe_empty", out_valid, 0);

        // First beat after reset arrives with latency 2.
        in_valid = 1'b1;
        in_sub   = 1'b1;
        in_sat   = 1'b1;
        X        = pk(7, 7, 7, 7);
        Y        = pk(2, 3, 4, 5);
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        if (in_ready) sb.push_back('{d: pk(5, 4, 3, 2), o: 4'b0000});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_out_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", out_valid, 1);
        @(posedge clk); #1;
        drain("post_rst");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
